uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial receive front end for the 6502 SoC. It samples the asynchronous `uart_rxd` pin, deserialises 8N1 frames and buffers the received bytes in a first-word-fall-through FIFO. The CPU-side bus glue reads the FIFO through this block. It sits directly between the board pin and the core's peripheral decode, upstream of the CPU read path.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 139: system clocks per bit (16 MHz / 115200). Legal range is ≥ 8.
- `FIFO_AW`, default 4: FIFO address width. Depth = 2^FIFO_AW.

Ports:
- `clk`  in  1  system clock; every register lives in this domain.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_rxd`  in  1  raw serial input; idles high.
- `rd_en`  in  1  pop the head entry. Ignored while `empty`.
- `rd_data`  out  8  head byte. Reads 0 while `empty`.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds 2^FIFO_AW bytes.
- `count`  out  FIFO_AW+1  number of bytes held.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `clr_err`  in  1  clears `overrun` and `frame_err`.
- `irq`  out  1  equals `!empty`, registered.

## Operation
- `uart_rxd` passes through a 2-flop synchroniser. Both flops reset to 1. All logic below uses the synchronised value `rxs`.
- Receive FSM states and transitions:
  - IDLE: go to START when `rxs` is 0.
  - START: wait CLKS_PER_BIT/2 (integer division) clocks, then sample. If `rxs` is 1, treat it as a glitch and return to IDLE. Otherwise reload the bit timer and go to DATA.
  - DATA: sample every CLKS_PER_BIT clocks. Take 8 bits, LSB first, into the shift register. Go to STOP after bit 7.
  - STOP: sample after CLKS_PER_BIT clocks.
    - If `rxs` is 1, push the byte and return to IDLE.
    - If `rxs` is 0, set `frame_err`, discard the byte and go to BREAK.
  - BREAK: stay until `rxs` is 1, then go to IDLE.
- Bit timer width is $clog2(CLKS_PER_BIT). The timer counts down and reloads on every sample.
- Push into a full FIFO with no pop in the same cycle: the byte is dropped, `overrun` is set and the contents are unchanged.
- Push and pop in the same cycle:
  - Both take effect whatever the fill level, so full stays full with no overrun.
  - When empty, only the push takes effect; `rd_en` is ignored.
- Pointers are FIFO_AW bits and wrap modulo depth. `count` is tracked separately.
- When `clr_err` and a new error event occur in the same cycle, the error event wins and the flag stays set.
- Reset values:
  - outputs: `empty`=1, `full`=0, `count`=0, `rd_data`=0, `overrun`=0, `frame_err`=0, `irq`=0
  - internal: FSM in IDLE, both pointers 0.
- Reset in mid-frame abandons the frame. The rest of that frame is resynchronised from IDLE, and stray low data bits may be taken as new start bits.

## Timing
- Latency from pin to synchronised value: 2 clocks.
- Samples fall at the bit centres: start edge + CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
- The push happens on the clock edge at the stop sample. `empty`, `count` and `rd_data` update on that edge.
- `irq` lags `empty` by 1 clock.
- `rd_en` at edge N: `rd_data` shows the next entry (or 0) and `count` decrements after edge N.
- The FSM returns to IDLE at the stop-bit centre. This leaves a half-bit margin for the next start edge.

## Structure
- Package `uart_pkg` holds:
  - the receive-state enum (IDLE, START, DATA, STOP, BREAK)
  - the 8-bit data width constant
  - the default CLKS_PER_BIT constant, shared with the future `uart_tx` block.
- Sub-module `sync_fifo`, parameterised by width and AW. It is a FWFT single-clock FIFO that provides `count`, `full`, `empty` and a `drop` pulse on push-while-full. It is reusable for TX.
- The top level of this block holds the synchroniser, the FSM, the bit timer, the shift register and the sticky flags.

## Test plan
All cases use CLKS_PER_BIT=16 and FIFO_AW=2 (depth 4).
- Single frame 0xA5, clean 8N1: `rd_data`=0xA5 and `count`=1, with `empty` falling exactly 2 + 8 + 9·16 clocks after the start edge. Pop: `empty`=1 and `rd_data`=0.
- Glitch: hold `uart_rxd` low for 5 clocks in idle: no push, FSM back in IDLE, no flags set.
- Frame 0x3C with the stop bit low, line held low for 40 clocks and then high: `frame_err`=1, `count`=0. A following 0x55 frame is received correctly. `clr_err` clears the flag.
- Overrun: send 5 frames 0x01 through 0x05 with no pops: `full`=1, `overrun`=1, and pops return 0x01, 0x02, 0x03, 0x04 in order.
- Full with simultaneous pop: fill with 4 bytes and assert `rd_en` on the cycle the 5th byte (0x99) pushes: `overrun`=0, `count`=4, and the last entry popped is 0x99.
- Reset in mid-frame: assert `reset` during data bit 3 of frame 0xF0, release it with the line high, then send 0x81: all outputs hold their reset values while `reset` is high, and only 0x81 is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-state encoding, data width and default bit timing.
// The transmit block will reuse the same constants.
package uart_pkg;

    localparam int DATA_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 139;  // 16 MHz / 115200 baud

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and a drop pulse
// on push-while-full. Shared by the UART receive and transmit paths.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             drop
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; empty masks rd_data, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: pin synchroniser, bit-centre sampling FSM and sticky error flags,
// feeding a FWFT receive FIFO read by the CPU bus glue.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rxd,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic                empty,
    output logic                full,
    output logic [FIFO_AW:0]    count,
    output logic                overrun,
    output logic                frame_err,
    input  logic                clr_err,
    output logic                irq
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_RELOAD   = TW'(CLKS_PER_BIT - 1);
    // The IDLE cycle that spots the synchronised low level counts toward the half-bit wait,
    // which puts every sample at sync edge + CLKS_PER_BIT/2 + k*CLKS_PER_BIT.
    localparam logic [TW-1:0] START_RELOAD = TW'(CLKS_PER_BIT / 2 - 2);

    logic              sync1;
    logic              rxs;
    rx_state_t         state;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              tick;
    logic              push;
    logic              frame_evt;
    logic              drop;

    // NOTE: both flops reset to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxs   <= sync1;
        end
    end

    assign tick      = (timer == '0);
    assign push      = (state == RX_STOP) && tick && rxs;
    assign frame_evt = (state == RX_STOP) && tick && !rxs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RX_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (!rxs) begin
                        state <= RX_START;
                        timer <= START_RELOAD;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        timer <= BIT_RELOAD;
                        if (rxs) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        timer   <= BIT_RELOAD;
                        shreg   <= {rxs, shreg[DATA_W-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        timer <= BIT_RELOAD;
                        state <= rxs ? RX_IDLE : RX_BREAK;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                RX_BREAK: begin
                    if (rxs) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // A new error event outranks a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
        end else begin
            irq <= !empty;
            if (drop)         overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (frame_evt)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .drop      (drop)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus a randomized frame/pop mix,
// compared against a byte-queue model of the receive FIFO and its sticky flags.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int PUSH_CYCLE = 2 + CPB / 2 + 9 * CPB;  // 154

    logic          clk = 1'b0;
    logic          reset;
    logic          uart_rxd;
    logic          rd_en;
    logic          clr_err;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          frame_err;
    logic          irq;

    int            n_checks = 0;
    int            n_fail   = 0;
    byte unsigned  q[$];
    bit            exp_ovr;
    bit            exp_fe;
    int            push_at;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rxd  (uart_rxd),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = q.size();
        check({tag, ":count"},     32'(count),     32'(n));
        check({tag, ":empty"},     32'(empty),     32'(n == 0));
        check({tag, ":full"},      32'(full),      32'(n == DEPTH));
        check({tag, ":rd_data"},   32'(rd_data),   (n == 0) ? 32'd0 : 32'(q[0]));
        check({tag, ":overrun"},   32'(overrun),   32'(exp_ovr));
        check({tag, ":frame_err"}, 32'(frame_err), 32'(exp_fe));
        check({tag, ":irq"},       32'(irq),       32'(n != 0));
    endtask

    // Drives one frame from a falling clock edge; cycle c of the loop sets up rising edge c+1.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stop_len,
                              input int pop_cyc, input int clr_cyc,
                              input int rst_on, input int rst_off);
        logic [9:0] bits;
        int         idx;
        int         prev;
        bits    = {stop_ok, b, 1'b0};
        push_at = -1;
        prev    = int'(count);
        for (int c = 0; c < 9 * CPB + stop_len; c++) begin
            idx      = c / CPB;
            uart_rxd = bits[(idx > 9) ? 9 : idx];
            rd_en    = (pop_cyc == c + 1);
            clr_err  = (clr_cyc == c + 1);
            reset    = (rst_on >= 0) && (c >= rst_on) && (c < rst_off);
            @(negedge clk);
            if (push_at < 0 && int'(count) > prev) push_at = c + 1;
            prev = int'(count);
            if (rst_on >= 0 && c == rst_on + 4) check_state("in_reset");
        end
        uart_rxd = 1'b1;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        reset    = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, 1'b1, CPB, 0, 0, -1, -1);
        if (q.size() == DEPTH) exp_ovr = 1'b1;
        else q.push_back(b);
    endtask

    task automatic pop_one(input string tag);
        if (q.size() != 0) begin
            check({tag, ":pop_data"}, 32'(rd_data), 32'(q[0]));
            void'(q.pop_front());
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
        @(negedge clk);
        check_state("clr_err");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        reset    = 1'b1;
        uart_rxd = 1'b1;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        exp_ovr  = 1'b0;
        exp_fe   = 1'b0;
        repeat (3) @(negedge clk);
        check_state("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_state("post_reset");

        // Single clean frame, exact push latency, then pop and a pop while empty.
        send_ok(8'hA5);
        check("a5:push_cycle", 32'(push_at), 32'(PUSH_CYCLE));
        check_state("a5");
        pop_one("a5_pop");
        pop_one("empty_pop");

        // Short low pulse in idle must be rejected as a glitch.
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (30) @(negedge clk);
        check_state("glitch");

        // Low stop bit with a 40-clock break, then a clean frame and a flag clear.
        send_frame(8'h3C, 1'b0, 40, 0, 0, -1, -1);
        exp_fe = 1'b1;
        check_state("break");
        send_ok(8'h55);
        check_state("after_break");
        clear_flags();
        pop_one("p55");

        // Overrun; the clear on the dropping cycle loses to the new event.
        for (int i = 1; i <= 4; i++) send_ok(8'(i));
        send_frame(8'h05, 1'b1, CPB, 0, PUSH_CYCLE, -1, -1);
        exp_ovr = 1'b1;
        check_state("overrun");
        clear_flags();
        for (int i = 0; i < 4; i++) pop_one("ovr_pop");

        // Push into a full FIFO with a pop on the same edge.
        for (int i = 0; i < 4; i++) send_ok(8'h11 + 8'(i));
        send_frame(8'h99, 1'b1, CPB, PUSH_CYCLE, 0, -1, -1);
        void'(q.pop_front());
        q.push_back(8'h99);
        check_state("full_pop");
        for (int i = 0; i < 4; i++) pop_one("fp_pop");

        // Randomized mix of good/bad frames, pops and flag clears.
        for (int n = 0; n < 16; n++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                send_frame(rb, 1'b0, $urandom_range(16, 40), 0, 0, -1, -1);
                exp_fe = 1'b1;
            end else begin
                send_ok(rb);
            end
            check_state("rand");
            repeat ($urandom_range(0, 2)) pop_one("rand_pop");
            if ($urandom_range(0, 3) == 0) clear_flags();
        end

        // Reset during data bit 3 of 0xF0, released while the line is high.
        send_ok(8'h42);
        send_frame(8'h00, 1'b0, 20, 0, 0, -1, -1);
        exp_fe = 1'b1;
        check_state("pre_reset");
        q.delete();
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
        send_frame(8'hF0, 1'b1, CPB, 0, 0, 4 * CPB + 6, 6 * CPB + 4);
        check_state("after_midframe_reset");
        send_ok(8'h81);
        check_state("f81");
        pop_one("f81_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
